// File: rtl/wb_leds_ctrl.sv
// wb_leds_ctrl: Wishbone slave LED controller with NUM_LEDS independent channels.
// Each channel is OFF, DIRECT (level from the DIRECT register), PWM-dimmed or
// BLINK. A shared prescaler produces the tick that drives the PWM counter and
// the per-channel blink counters.
//
// Ports:
//   clk_i, rst_n_i       clock, asynchronous active-low reset
//   wb_adr_i..wb_stb_i   Wishbone slave request (only adr[7:2] decoded)
//   wb_dat_o             registered read data, valid with wb_ack_o
//   wb_ack_o / wb_err_o  one-cycle termination per accepted request
//   wb_rty_o             always 0
//   wb_stall_o           high while a request is waiting for its termination
//   leds_o               registered LED drive (inverted when ACTIVE_LOW=1)
module wb_leds_ctrl #(
  parameter int unsigned NUM_LEDS   = 8,
  parameter int unsigned PWM_BITS   = 8,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [31:0]         wb_adr_i,
  input  logic [31:0]         wb_dat_i,
  input  logic [3:0]          wb_sel_i,
  input  logic                wb_we_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  output logic [31:0]         wb_dat_o,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic                wb_rty_o,
  output logic                wb_stall_o,
  output logic [NUM_LEDS-1:0] leds_o
);

  localparam int unsigned         CH_BASE = 8;
  localparam logic [NUM_LEDS-1:0] POL     = {NUM_LEDS{ACTIVE_LOW}};

  // Register file
  logic                en;
  logic [15:0]         presc;
  logic [NUM_LEDS-1:0] direct;
  logic [1:0]          mode [NUM_LEDS];
  logic [PWM_BITS-1:0] duty [NUM_LEDS];
  logic [15:0]         half [NUM_LEDS];

  // Time base and channel state
  logic [15:0]         presc_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [15:0]         blink_cnt [NUM_LEDS];
  logic [NUM_LEDS-1:0] phase;
  logic [NUM_LEDS-1:0] ch_out;
  logic                tick;

  // Bus decode
  logic                req, addr_ok, wr;
  logic                hit_ctrl, hit_direct, hit_status;
  logic [NUM_LEDS-1:0] hit_ch;
  logic [5:0]          word;
  logic [31:0]         rdata;
  logic                unused_bits;

  assign unused_bits = ^{wb_adr_i[31:8], wb_adr_i[1:0]};

  assign req        = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
  assign wb_stall_o = wb_cyc_i & wb_stb_i & ~(wb_ack_o | wb_err_o);
  assign wb_rty_o   = 1'b0;
  assign word       = wb_adr_i[7:2];
  assign hit_ctrl   = (word == 6'd0);
  assign hit_direct = (word == 6'd1);
  assign hit_status = (word == 6'd2);

  always_comb begin
    for (int i = 0; i < NUM_LEDS; i++)
      hit_ch[i] = (word == 6'(CH_BASE + i));
  end

  assign addr_ok = hit_ctrl | hit_direct | hit_status | (|hit_ch);
  assign wr      = req & wb_we_i & addr_ok;

  // Byte-lane merged values of a CTRL write
  logic        ctrl_wr, en_nxt, en_clr, presc_reload;
  logic [15:0] presc_nxt;

  assign ctrl_wr   = wr & hit_ctrl;
  assign en_nxt    = wb_sel_i[0] ? wb_dat_i[0] : en;
  assign presc_nxt = {wb_sel_i[3] ? wb_dat_i[31:24] : presc[15:8],
                      wb_sel_i[2] ? wb_dat_i[23:16] : presc[7:0]};
  // Clearing EN zeroes the time base on the same edge it takes effect.
  assign en_clr       = ~en | (ctrl_wr & ~en_nxt);
  // Enabling, or changing PRESC while enabled, restarts the prescaler so the
  // first tick lands PRESC+1 cycles later.
  assign presc_reload = ctrl_wr & en_nxt & ((presc_nxt != presc) | ~en);
  assign tick         = en & (presc_cnt == 16'd0);

  always_comb begin
    rdata = '0;
    if (hit_ctrl)   rdata = {presc, 15'd0, en};
    if (hit_direct) rdata[NUM_LEDS-1:0] = direct;
    if (hit_status) rdata[NUM_LEDS-1:0] = leds_o ^ POL;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (hit_ch[i]) begin
        rdata[1:0]           = mode[i];
        rdata[8 +: PWM_BITS] = duty[i];
        rdata[31:16]         = half[i];
      end
    end
  end

  // Bus termination: one ack or err the edge after acceptance
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      if (req) begin
        if (addr_ok) begin
          wb_ack_o <= 1'b1;
          wb_dat_o <= wb_we_i ? 32'd0 : rdata;
        end else begin
          wb_err_o <= 1'b1;
          wb_dat_o <= 32'd0;
        end
      end
    end
  end

  // Register writes
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      en     <= 1'b0;
      presc  <= '0;
      direct <= '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        mode[i] <= '0;
        duty[i] <= '0;
        half[i] <= '0;
      end
    end else if (wr) begin
      if (hit_ctrl) begin
        en    <= en_nxt;
        presc <= presc_nxt;
      end
      if (hit_direct) begin
        for (int j = 0; j < NUM_LEDS; j++)
          if (wb_sel_i[j/8]) direct[j] <= wb_dat_i[j];
      end
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (hit_ch[i]) begin
          if (wb_sel_i[0]) mode[i]       <= wb_dat_i[1:0];
          if (wb_sel_i[1]) duty[i]       <= wb_dat_i[8 +: PWM_BITS];
          if (wb_sel_i[2]) half[i][7:0]  <= wb_dat_i[23:16];
          if (wb_sel_i[3]) half[i][15:8] <= wb_dat_i[31:24];
        end
      end
    end
  end

  // Prescaler and PWM counter
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
    end else begin
      if (presc_reload)    presc_cnt <= presc_nxt;
      else if (en_clr)     presc_cnt <= '0;
      else if (tick)       presc_cnt <= presc;
      else                 presc_cnt <= presc_cnt - 16'd1;

      if (en_clr)          pwm_cnt <= '0;
      else if (tick)       pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  // Blink counters; a channel write restarts the on phase even if a tick
  // arrives on the same edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      phase <= '0;
      for (int i = 0; i < NUM_LEDS; i++) blink_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (en_clr || (wr && hit_ch[i])) begin
          blink_cnt[i] <= '0;
          phase[i]     <= 1'b0;
        end else if (tick) begin
          if (blink_cnt[i] >= half[i]) begin
            blink_cnt[i] <= '0;
            phase[i]     <= ~phase[i];
          end else begin
            blink_cnt[i] <= blink_cnt[i] + 16'd1;
          end
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_LEDS; i++) begin
      ch_out[i] = 1'b0;
      if (en) begin
        case (mode[i])
          2'd1:    ch_out[i] = direct[i];
          2'd2:    ch_out[i] = (pwm_cnt < duty[i]);
          2'd3:    ch_out[i] = ~phase[i];
          default: ch_out[i] = 1'b0;
        endcase
      end
    end
  end

  // Output register with polarity applied
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) leds_o <= POL;
    else          leds_o <= ch_out ^ POL;
  end

endmodule

// File: tb/tb_wb_leds_ctrl.sv
// Testbench for wb_leds_ctrl: directed Wishbone transactions, a tick-count
// reference model compared against the DUT every cycle, and hand-computed
// literal expectations for the key scenarios.
module tb_wb_leds_ctrl;
  localparam int NUM_LEDS   = 8;
  localparam int PWM_BITS   = 8;
  localparam bit ACTIVE_LOW = 1'b0;
  localparam logic [NUM_LEDS-1:0] POL = {NUM_LEDS{ACTIVE_LOW}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic [31:0]         adr, dat_w, dat_r;
  logic [3:0]          sel;
  logic                we, cyc, stb;
  logic                ack, err, rty, stall;
  logic [NUM_LEDS-1:0] leds;

  int n_checks = 0;
  int n_errors = 0;

  wb_leds_ctrl #(.NUM_LEDS(NUM_LEDS), .PWM_BITS(PWM_BITS), .ACTIVE_LOW(ACTIVE_LOW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_dat_o(dat_r), .wb_ack_o(ack),
    .wb_err_o(err), .wb_rty_o(rty), .wb_stall_o(stall), .leds_o(leds)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Registers as the bus has written them, plus elapsed-time quantities:
  // cycles since the prescaler was (re)started, ticks since enable (PWM
  // position) and ticks since each channel was last written (blink position).
  bit                  m_en;
  logic [15:0]         m_presc;
  logic [NUM_LEDS-1:0] m_direct;
  logic [1:0]          m_mode [NUM_LEDS];
  logic [PWM_BITS-1:0] m_duty [NUM_LEDS];
  logic [15:0]         m_half [NUM_LEDS];
  longint              m_since_load, m_ticks;
  longint              m_ch_ticks [NUM_LEDS];
  logic [NUM_LEDS-1:0] m_led;
  bit                  m_ack, m_err, m_rd;
  logic [31:0]         m_dat;

  function automatic void model_reset();
    m_en = 0; m_presc = '0; m_direct = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      m_mode[i] = '0; m_duty[i] = '0; m_half[i] = '0; m_ch_ticks[i] = 0;
    end
    m_since_load = 0; m_ticks = 0; m_led = '0;
    m_ack = 0; m_err = 0; m_rd = 0; m_dat = '0;
  endfunction

  function automatic bit addr_valid(input int w);
    return (w <= 2) || (w >= 8 && w < 8 + NUM_LEDS);
  endfunction

  function automatic logic [31:0] model_read(input int w);
    logic [31:0] r = '0;
    if (w == 0) r = {m_presc, 15'd0, m_en};
    else if (w == 1) r[NUM_LEDS-1:0] = m_direct;
    else if (w == 2) r[NUM_LEDS-1:0] = m_led;
    else if (w >= 8 && w < 8 + NUM_LEDS) begin
      r[1:0] = m_mode[w-8]; r[8 +: PWM_BITS] = m_duty[w-8]; r[31:16] = m_half[w-8];
    end
    return r;
  endfunction

  function automatic logic [NUM_LEDS-1:0] model_leds();
    logic [NUM_LEDS-1:0] v = '0;
    longint per;
    if (m_en) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        case (m_mode[i])
          2'd1: v[i] = m_direct[i];
          2'd2: v[i] = (m_ticks % (longint'(1) << PWM_BITS)) < longint'(m_duty[i]);
          2'd3: begin
            per  = 2 * (longint'(m_half[i]) + 1);
            v[i] = (m_ch_ticks[i] % per) <= longint'(m_half[i]);
          end
          default: v[i] = 1'b0;
        endcase
      end
    end
    return v;
  endfunction

  // Advance the model across the next rising edge given the present inputs.
  task automatic model_step();
    bit tick, req, ok, wr, ctrl_wr, en_clr, reload, new_en;
    logic [15:0] new_presc;
    logic [NUM_LEDS-1:0] nled, ch_wr;
    int w;
    tick = m_en && ((m_since_load % (longint'(m_presc) + 1)) == longint'(m_presc));
    nled = model_leds();
    req  = cyc && stb && !m_ack && !m_err;
    w    = int'(adr[7:2]);
    ok   = addr_valid(w);
    if (req) m_dat = (ok && !we) ? model_read(w) : 32'd0;
    m_ack = req && ok; m_err = req && !ok; m_rd = req && ok && !we;
    wr = req && ok && we;
    new_en = m_en; new_presc = m_presc; ch_wr = '0;
    if (wr) begin
      if (w == 0) begin
        if (sel[0]) new_en = dat_w[0];
        if (sel[2]) new_presc[7:0]  = dat_w[23:16];
        if (sel[3]) new_presc[15:8] = dat_w[31:24];
      end
      if (w == 1)
        for (int j = 0; j < NUM_LEDS; j++) if (sel[j/8]) m_direct[j] = dat_w[j];
      if (w >= 8 && w < 8 + NUM_LEDS) begin
        ch_wr[w-8] = 1'b1;
        if (sel[0]) m_mode[w-8] = dat_w[1:0];
        if (sel[1]) m_duty[w-8] = dat_w[8 +: PWM_BITS];
        if (sel[2]) m_half[w-8][7:0]  = dat_w[23:16];
        if (sel[3]) m_half[w-8][15:8] = dat_w[31:24];
      end
    end
    ctrl_wr = wr && (w == 0);
    en_clr  = !m_en || (ctrl_wr && !new_en);
    reload  = ctrl_wr && new_en && ((new_presc != m_presc) || !m_en);
    if (en_clr) begin
      m_ticks = 0;
      for (int i = 0; i < NUM_LEDS; i++) m_ch_ticks[i] = 0;
    end else begin
      if (tick) m_ticks++;
      for (int i = 0; i < NUM_LEDS; i++)
        if (ch_wr[i]) m_ch_ticks[i] = 0;
        else if (tick) m_ch_ticks[i]++;
    end
    if (reload || en_clr) m_since_load = 0;
    else m_since_load++;
    m_en = new_en; m_presc = new_presc; m_led = nled;
  endtask

  initial model_reset();

  // Compare process: every falling edge
  always @(negedge clk) begin
    if (!rst_n) model_reset();
    check("leds_o", 32'(leds), 32'(m_led ^ POL));
    check("ack", 32'(ack), 32'(m_ack));
    check("err", 32'(err), 32'(m_err));
    check("rty", 32'(rty), 32'd0);
    check("stall", 32'(stall), 32'(cyc & stb & ~(m_ack | m_err)));
    if (m_rd || m_err) check("dat_o", dat_r, m_dat);
    if (rst_n) model_step();
  end

  // ---------------- bus tasks ----------------
  task automatic wb_xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input bit w, output logic [31:0] rd, output bit got_ack, output bit got_err);
    @(posedge clk); #1;
    adr = a; dat_w = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
    got_ack = 0; got_err = 0; rd = '0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (ack || err) begin
        got_ack = ack; got_err = err; rd = dat_r;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    check("bus_terminated", 32'(got_ack | got_err), 32'd1);
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd; bit ga, ge;
    wb_xfer(a, d, s, 1'b1, rd, ga, ge);
  endtask

  task automatic wb_read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd; bit ga, ge;
    wb_xfer(a, 32'd0, 4'hF, 1'b0, rd, ga, ge);
    check(name, rd, exp);
  endtask

  task automatic count_led(input int bit_idx, input int cycles, output int hi);
    hi = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      if (leds[bit_idx]) hi++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    bit ga, ge;
    int hi, waited;
    rst_n = 1'b0; adr = '0; dat_w = '0; sel = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset defaults; cyc without stb must not be acked
    cyc = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_leds", 32'(leds), 32'h0);
    check("no_ack_without_stb", 32'(ack | err), 32'd0);
    cyc = 1'b0;
    wb_read_check("rst_ctrl",   32'h00, 32'h0);
    wb_read_check("rst_direct", 32'h04, 32'h0);
    wb_read_check("rst_status", 32'h08, 32'h0);
    for (int i = 0; i < NUM_LEDS; i++) wb_read_check("rst_ch", 32'h20 + 32'(4*i), 32'h0);

    // DIRECT path
    wb_write(32'h00, 32'h1, 4'hF);
    for (int i = 0; i < NUM_LEDS; i++) wb_write(32'h20 + 32'(4*i), 32'h1, 4'hF);
    wb_write(32'h04, 32'hA5, 4'hF);
    check("direct_not_yet", 32'(leds), 32'h00);
    @(posedge clk); #1;
    check("direct_a5", 32'(leds), 32'hA5);
    wb_write(32'h04, 32'hFF, 4'h0);
    wb_read_check("direct_sel0", 32'h04, 32'hA5);
    wb_read_check("status_a5", 32'h08, 32'hA5);

    // PWM at one tick per cycle
    wb_write(32'h20, 32'h0000_4002, 4'hF);
    count_led(0, 256, hi);
    check("pwm_duty64", 32'(hi), 32'd64);
    wb_write(32'h20, 32'h0000_0002, 4'hF);
    count_led(0, 256, hi);
    check("pwm_duty0", 32'(hi), 32'd0);

    // Blink: PRESC=9, HALF=4 -> 50 cycles on, 50 off
    wb_write(32'h00, 32'h0009_0001, 4'hF);
    wb_write(32'h24, 32'h0004_0003, 4'hF);
    @(posedge clk); #1;
    count_led(1, 100, hi);
    check("blink_50_of_100", 32'(hi), 32'd50);
    waited = 0;
    while (leds[1] && waited < 200) begin @(posedge clk); #1; waited++; end
    check("blink_reached_off", 32'(leds[1]), 32'd0);
    wb_write(32'h24, 32'h0004_0003, 4'hF);
    @(posedge clk); #1;
    check("blink_restart_on", 32'(leds[1]), 32'd1);
    wb_read_check("ch1_readback", 32'h24, 32'h0004_0003);

    // Bus errors and STATUS write
    wb_xfer(32'h40, 32'h0, 4'hF, 1'b0, rd, ga, ge);
    check("err40_err", 32'(ge), 32'd1);
    check("err40_ack", 32'(ga), 32'd0);
    check("err40_dat", rd, 32'd0);
    wb_xfer(32'h0C, 32'hFFFF_FFFF, 4'hF, 1'b1, rd, ga, ge);
    check("err0c_err", 32'(ge), 32'd1);
    check("err0c_ack", 32'(ga), 32'd0);
    wb_read_check("ctrl_kept", 32'h00, 32'h0009_0001);
    wb_xfer(32'h08, 32'hFF, 4'hF, 1'b1, rd, ga, ge);
    check("status_wr_ack", 32'(ga), 32'd1);
    check("status_wr_err", 32'(ge), 32'd0);
    wb_read_check("direct_kept", 32'h04, 32'hA5);

    // Clear EN mid-blink, then re-enable: counters must restart from zero
    wb_write(32'h00, 32'h0009_0000, 4'hF);
    @(posedge clk); #1;
    check("en0_leds", 32'(leds), 32'h0);
    wb_read_check("en0_status", 32'h08, 32'h0);
    wb_write(32'h00, 32'h0009_0001, 4'hF);
    hi = 0;
    @(posedge clk); #1;
    while (leds[1] && hi < 200) begin hi++; @(posedge clk); #1; end
    check("reenable_on_run", 32'(hi), 32'd50);

    // Reset during a pending write
    wb_write(32'h00, 32'h0, 4'hF);
    @(posedge clk); #1;
    adr = 32'h04; dat_w = 32'h3C; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_drops_ack", 32'(ack), 32'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_mid_leds", 32'(leds), 32'h0);
    wb_read_check("rst_mid_direct", 32'h04, 32'h0);
    wb_read_check("rst_mid_ch1", 32'h24, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_leds_ctrl.md
# wb_leds_ctrl

Parametrised Wishbone LED controller, successor to the fixed 32-bit LED register block. Drives `NUM_LEDS` outputs, each independently set to off, direct, PWM-dimmed or blinking mode. A shared prescaler sets the time base for all channels. It sits on the peripheral Wishbone bus as a slave and drives board LEDs directly.

## Interface

**Parameters**
- `NUM_LEDS`, default 8: number of channels, 1..32.
- `PWM_BITS`, default 8: PWM counter and duty width, 1..8.
- `ACTIVE_LOW`, default 0: when 1, `leds_o` is inverted at the output register.

**Ports**
- `clk_i`  in  1: single clock.
- `rst_n_i`  in  1: reset, asynchronous, active-low.
- `wb_adr_i`  in  32: byte address; only `[7:2]` is decoded.
- `wb_dat_i`  in  32: write data.
- `wb_sel_i`  in  4: byte-lane enables, honoured on writes.
- `wb_we_i`  in  1: write enable.
- `wb_cyc_i`  in  1: bus cycle.
- `wb_stb_i`  in  1: strobe.
- `wb_dat_o`  out  32: read data, registered.
- `wb_ack_o`  out  1: normal termination.
- `wb_err_o`  out  1: error termination.
- `wb_rty_o`  out  1: tied 0.
- `wb_stall_o`  out  1: stall.
- `leds_o`  out  `NUM_LEDS`: LED drive, registered.

## Operation

**Register map** (word index = `adr[7:2]`). All fields reset to 0; unlisted bits read 0.
- 0x00 CTRL (RW):
  - `[0]` EN, global enable.
  - `[31:16]` PRESC, prescaler reload.
- 0x04 DIRECT (RW): `[NUM_LEDS-1:0]` level used by channels in DIRECT mode.
- 0x08 STATUS (RO): `[NUM_LEDS-1:0]` current pre-polarity LED state. Writes are acked and ignored.
- 0x20+4·i CHi (RW), for i < `NUM_LEDS`:
  - `[1:0]` MODE: 0 OFF, 1 DIRECT, 2 PWM, 3 BLINK.
  - `[15:8]` DUTY; only the low `PWM_BITS` bits are used, unused bits read 0.
  - `[31:16]` HALF, blink half-period in ticks.
- Any other address, including CHi with i ≥ `NUM_LEDS`, terminates with `wb_err_o`. No register changes and read data is 0.

**Bus access**
- A request is accepted when `cyc & stb & ~ack & ~err`.
- Exactly one ack or err pulse is issued per accepted request.
- `wb_stall_o = cyc & stb & ~(ack|err)`, so both classic and pipelined masters see one access per two cycles.

**Time base**
- The prescaler counter loads PRESC and decrements each cycle. When it reaches 0 it emits a one-cycle `tick` and reloads.
- PRESC=0 gives a tick every cycle.
- A CTRL write that changes PRESC reloads the counter immediately.

**PWM**
- A shared `PWM_BITS` counter increments on each tick and wraps to 0.
- PWM channel output = (pwm_cnt < DUTY).
- DUTY=0 is always off. DUTY=2^PWM_BITS−1 is on for (2^PWM_BITS−1) of 2^PWM_BITS ticks.

**Blink**
- Each channel has a 16-bit counter and a phase bit.
- On each tick: if cnt ≥ HALF, then cnt←0 and phase toggles; otherwise cnt++.
- Period = 2·(HALF+1) ticks. Output = ~phase, so phase 0 means on.
- Any write to CHi, regardless of `wb_sel_i`, clears that channel's cnt and phase.

**Channel output**
- OFF → 0.
- DIRECT → DIRECT[i].
- PWM → compare result.
- BLINK → ~phase.

**Global enable**
- EN=0 forces all channel outputs to 0.
- EN=0 holds the prescaler, PWM counter and all blink counters/phases at 0.
- On EN 0→1, the first tick occurs PRESC+1 cycles later.

**Simultaneous events**
- A CHi write and a tick in the same cycle: the write wins, so cnt=0 and phase=0.
- Register writes and output updates are never lost.

## Timing

**Reset**
- Asynchronous assertion clears all registers, counters and `wb_ack_o`/`wb_err_o`/`wb_dat_o`.
- `leds_o` resets to all-0, or all-1 when `ACTIVE_LOW`=1.
- `wb_stall_o` follows its combinational equation.
- Reset asserted mid-access drops the pending ack; the master must restart.

**Latency**
- Ack/err is asserted on the edge after acceptance and held for 1 cycle.
- Write data takes effect on that same edge.
- Read data is valid with ack.
- `leds_o` reflects a register or counter change 1 cycle after the internal state updates, i.e. 2 cycles after request acceptance for a DIRECT write.

**Widths**
- Unsigned compares throughout.
- Counters wrap silently; the blink counter cannot exceed HALF.

## Test plan

- **Reset defaults:** reset, then read all registers → all 0. `leds_o`=0x00 (`ACTIVE_LOW`=0). No ack without stb.
- **DIRECT path:**
  - Write CTRL=0x1, DIRECT=0xA5, CH0..7 MODE=1 → `leds_o`=0xA5 two cycles after the DIRECT accept.
  - Write DIRECT with sel=0x0 → unchanged.
- **PWM:** PRESC=0, EN=1, CH0 MODE=2, DUTY=64 → `leds_o[0]` high for exactly 64 of every 256 cycles. DUTY=0 → never high.
- **Blink:**
  - PRESC=9, CH1 MODE=3, HALF=4 → `leds_o[1]` on 50 cycles, off 50 cycles.
  - Rewriting CH1 mid-period restarts the on phase.
- **Bus errors:** access 0x40 with `NUM_LEDS`=8 and 0x0C → `wb_err_o` one cycle, no ack, rdata 0, no state change. STATUS write acks without effect.
- **EN and reset mid-operation:**
  - Clear EN during blink → outputs 0, counters 0.
  - Assert `rst_n_i` during a pending write → no ack, register stays 0.
